// File: rtl/global_demux_wr.sv
// ---------------------------------------------------------------------------
// global_demux_wr
//
// Write-side demux that steers one write word from the core store path to
// one of two peripheral write ports (target 0 = GPIO, target 1 = FACT).
// Every port uses a valid/ready handshake. Exactly one transfer is held at a
// time, and a new write can be accepted in the same cycle the held one
// completes, so back-to-back traffic runs at one transfer per cycle.
//
// Optional feature macro: GLOBAL_DEMUX_TIMEOUT_EN
//   Defined   : a stall counter drops a held transfer after TIMEOUT stalled
//               cycles and raises the sticky timeout_err flag.
//   Undefined : HOLD waits indefinitely, timeout_err is tied low and err_clr
//               is ignored.
//
// Parameters:
//   WIDTH    data width in bits
//   TIMEOUT  stalled HOLD cycles before a transfer is dropped (>= 1)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     core presents a write
//   in_ready     demux accepts the write this cycle
//   s            target select, sampled on acceptance (0 = GPIO, 1 = FACT)
//   d            write data
//   out0_valid   write pending to target 0
//   out0_ready   target 0 accepts
//   y0           data to target 0 (zero when not selected)
//   out1_valid   write pending to target 1
//   out1_ready   target 1 accepts
//   y1           data to target 1 (zero when not selected)
//   busy         a transfer is held
//   err_clr      clears timeout_err
//   timeout_err  sticky flag: a held transfer was dropped
// ---------------------------------------------------------------------------
module global_demux_wr #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s,
  input  logic [WIDTH-1:0] d,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] y0,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] y1,
  output logic             busy,
  input  logic             err_clr,
  output logic             timeout_err
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             sel_r;
  logic             sel_nxt;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] data_nxt;

  logic             sel_ready;
  logic             in_hold;
  logic             hold_done;
  logic             stalled;
  logic             drop;
  logic             hold_vis;

  // Only the ready of the currently selected target matters; the other
  // target's ready is ignored in every state.
  assign sel_ready = sel_r ? out1_ready : out0_ready;
  assign in_hold   = (state == HOLD);
  assign hold_done = in_hold && sel_ready;
  assign stalled   = in_hold && !sel_ready;

  // The core may hand over a new word when nothing is held, or in the very
  // cycle the held word completes. This depends only on state and the
  // selected ready, never on in_valid, so no combinational loop can form
  // through the core's handshake logic.
  assign in_ready = !rst && ((state == IDLE) || hold_done);

`ifdef GLOBAL_DEMUX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] stall_inc;
  logic          err_r;

  // The drop fires on the edge where the counter would reach TIMEOUT, so the
  // dropped transfer's valid is visible for exactly TIMEOUT cycles.
  assign stall_inc = stall_cnt + 1'b1;
  assign drop      = stalled && (stall_inc == CW'(TIMEOUT));

  // Stall counter: counts consecutive stalled HOLD cycles. It restarts on
  // completion, on a new capture, on a drop and whenever the demux is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stalled && !drop) begin
      stall_cnt <= stall_inc;
    end else begin
      stall_cnt <= '0;
    end
  end

  // Sticky error flag. A timeout in the same cycle as err_clr wins so that
  // a drop can never be lost to a concurrent clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (drop) begin
      err_r <= 1'b1;
    end else if (err_clr) begin
      err_r <= 1'b0;
    end
  end

  assign timeout_err = err_r;
`else
  localparam int unused_timeout = TIMEOUT;

  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign drop           = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  // State register plus the held select and data. Reset discards any held
  // transfer silently; the error flag is handled separately above.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel_r  <= 1'b0;
      data_r <= '0;
    end else begin
      state  <= state_nxt;
      sel_r  <= sel_nxt;
      data_r <= data_nxt;
    end
  end

  // Next-state logic. sel/data only move on an accepted write, so they stay
  // frozen for the whole of a stalled HOLD.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_r;
    data_nxt  = data_r;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          sel_nxt   = s;
          data_nxt  = d;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (sel_ready) begin
          if (in_valid) begin
            sel_nxt   = s;
            data_nxt  = d;
            state_nxt = HOLD;
          end else begin
            state_nxt = IDLE;
          end
        end else if (drop) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode. Outputs come from registered state, so valid/data appear
  // the cycle after acceptance. They are also masked while rst is high so
  // nothing leaks to the targets during the reset cycle itself.
  assign hold_vis   = in_hold && !rst;
  assign busy       = hold_vis;
  assign out0_valid = hold_vis && !sel_r;
  assign out1_valid = hold_vis && sel_r;
  assign y0         = out0_valid ? data_r : '0;
  assign y1         = out1_valid ? data_r : '0;

`ifndef SYNTHESIS
  // At most one target may see a pending write.
  a_onehot_valid : assert property (@(posedge clk) !(out0_valid && out1_valid));

  // A stalled transfer must keep its target and data untouched.
  a_stall_stable : assert property (@(posedge clk) disable iff (rst)
    (stalled && !drop) |=> ($stable(data_r) && $stable(sel_r)));
`endif

endmodule

// File: tb/tb_global_demux_wr.sv
// ---------------------------------------------------------------------------
// tb_global_demux_wr
//
// Directed, table-driven bench for global_demux_wr (WIDTH=8, TIMEOUT=16).
// Each record describes one clock cycle: the inputs driven during that cycle
// and the outputs expected just before the next rising edge. Inputs are
// driven 1 time unit after the rising edge and outputs are sampled on the
// falling edge. Timeout sequences follow GLOBAL_DEMUX_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_global_demux_wr;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             s;
  logic [WIDTH-1:0] d;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] y0;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] y1;
  logic             busy;
  logic             err_clr;
  logic             timeout_err;

  int vecCount;
  int missCount;

  typedef struct {
    string            name;
    logic             rst;
    logic             in_valid;
    logic             s;
    logic [WIDTH-1:0] d;
    logic             out0_ready;
    logic             out1_ready;
    logic             err_clr;
    logic             exp_in_ready;
    logic             exp_v0;
    logic [WIDTH-1:0] exp_y0;
    logic             exp_v1;
    logic [WIDTH-1:0] exp_y1;
    logic             exp_busy;
    logic             exp_err;
  } vec_t;

  vec_t vecs[$];

  global_demux_wr #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .s           (s),
    .d           (d),
    .out0_valid  (out0_valid),
    .out0_ready  (out0_ready),
    .y0          (y0),
    .out1_valid  (out1_valid),
    .out1_ready  (out1_ready),
    .y1          (y1),
    .busy        (busy),
    .err_clr     (err_clr),
    .timeout_err (timeout_err)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build one cycle record from inputs and hand-computed expectations.
  function automatic vec_t mk(string nm,
                              logic r, logic iv, logic sel, logic [WIDTH-1:0] dat,
                              logic r0, logic r1, logic clr,
                              logic eir, logic ev0, logic [WIDTH-1:0] ey0,
                              logic ev1, logic [WIDTH-1:0] ey1,
                              logic ebusy, logic eerr);
    vec_t v;
    v.name         = nm;
    v.rst          = r;
    v.in_valid     = iv;
    v.s            = sel;
    v.d            = dat;
    v.out0_ready   = r0;
    v.out1_ready   = r1;
    v.err_clr      = clr;
    v.exp_in_ready = eir;
    v.exp_v0       = ev0;
    v.exp_y0       = ey0;
    v.exp_v1       = ev1;
    v.exp_y1       = ey1;
    v.exp_busy     = ebusy;
    v.exp_err      = eerr;
    return v;
  endfunction

  // Drive the inputs of one record.
  task automatic applyStimulus(input vec_t v);
    rst        = v.rst;
    in_valid   = v.in_valid;
    s          = v.s;
    d          = v.d;
    out0_ready = v.out0_ready;
    out1_ready = v.out1_ready;
    err_clr    = v.err_clr;
  endtask

  // Compare every output against the record's expectations.
  task automatic checkOutput(input vec_t v);
    logic [2*WIDTH+4:0] got;
    logic [2*WIDTH+4:0] want;
    got  = {in_ready, out0_valid, y0, out1_valid, y1, busy, timeout_err};
    want = {v.exp_in_ready, v.exp_v0, v.exp_y0, v.exp_v1, v.exp_y1,
            v.exp_busy, v.exp_err};
    vecCount++;
    if (got !== want) begin
      missCount++;
      $display("[TB] FAIL %s: got ir=%b v0=%b y0=%h v1=%b y1=%h busy=%b err=%b, expected ir=%b v0=%b y0=%h v1=%b y1=%h busy=%b err=%b",
               v.name, in_ready, out0_valid, y0, out1_valid, y1, busy, timeout_err,
               v.exp_in_ready, v.exp_v0, v.exp_y0, v.exp_v1, v.exp_y1,
               v.exp_busy, v.exp_err);
    end
  endtask

  // One full cycle: drive, sample on the falling edge, advance past the edge.
  task automatic runVec(input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput(v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecCount   = 0;
    missCount  = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    s          = 1'b0;
    d          = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    err_clr    = 1'b0;

    // ---- Table: reset, single write, back-to-back, backpressure, reset mid-HOLD
    //                name          rst iv s  d      r0 r1 clr  ir v0 y0     v1 y1     bsy err
    vecs.push_back(mk("rst_a",       1, 1, 0, 8'hFF, 1, 1, 0,   0, 0, 8'h00, 0, 8'h00, 0, 0));
    vecs.push_back(mk("rst_b",       1, 1, 1, 8'hEE, 1, 1, 0,   0, 0, 8'h00, 0, 8'h00, 0, 0));
    vecs.push_back(mk("post_rst",    0, 0, 0, 8'h00, 0, 0, 0,   1, 0, 8'h00, 0, 8'h00, 0, 0));
    vecs.push_back(mk("wr0_accept",  0, 1, 0, 8'hA5, 1, 0, 0,   1, 0, 8'h00, 0, 8'h00, 0, 0));
    vecs.push_back(mk("wr0_out",     0, 0, 0, 8'h00, 1, 0, 0,   1, 1, 8'hA5, 0, 8'h00, 1, 0));
    vecs.push_back(mk("wr0_idle",    0, 0, 0, 8'h00, 1, 0, 0,   1, 0, 8'h00, 0, 8'h00, 0, 0));
    vecs.push_back(mk("b2b_acc1",    0, 1, 1, 8'h11, 1, 1, 0,   1, 0, 8'h00, 0, 8'h00, 0, 0));
    vecs.push_back(mk("b2b_out1",    0, 1, 0, 8'h22, 1, 1, 0,   1, 0, 8'h00, 1, 8'h11, 1, 0));
    vecs.push_back(mk("b2b_out0",    0, 0, 0, 8'h00, 1, 1, 0,   1, 1, 8'h22, 0, 8'h00, 1, 0));
    vecs.push_back(mk("b2b_idle",    0, 0, 0, 8'h00, 1, 1, 0,   1, 0, 8'h00, 0, 8'h00, 0, 0));
    vecs.push_back(mk("bp_accept",   0, 1, 1, 8'h3C, 1, 0, 0,   1, 0, 8'h00, 0, 8'h00, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk($sformatf("bp_stall%0d", i),
                                     0, 1, 0, 8'h55, 1, 0, 0,   0, 0, 8'h00, 1, 8'h3C, 1, 0));
    vecs.push_back(mk("bp_done",     0, 0, 0, 8'h00, 1, 1, 0,   1, 0, 8'h00, 1, 8'h3C, 1, 0));
    vecs.push_back(mk("bp_idle",     0, 0, 0, 8'h00, 1, 1, 0,   1, 0, 8'h00, 0, 8'h00, 0, 0));
    vecs.push_back(mk("mrst_accept", 0, 1, 1, 8'h77, 0, 0, 0,   1, 0, 8'h00, 0, 8'h00, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk($sformatf("mrst_stall%0d", i),
                                     0, 0, 0, 8'h00, 0, 0, 0,   0, 0, 8'h00, 1, 8'h77, 1, 0));
    vecs.push_back(mk("mrst_rst",    1, 0, 0, 8'h00, 0, 0, 0,   0, 0, 8'h00, 0, 8'h00, 0, 0));
    vecs.push_back(mk("mrst_after",  0, 0, 0, 8'h00, 0, 0, 0,   1, 0, 8'h00, 0, 8'h00, 0, 0));

    // One unchecked reset edge so every register starts from a known value.
    @(posedge clk);
    #1;
    $display("[TB] applying %0d table vectors", vecs.size());
    foreach (vecs[i]) runVec(vecs[i]);

    // ---- Hand-written sequence: stalled target 0
    runVec(mk("to_accept", 0, 1, 0, 8'h9A, 0, 0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0));
`ifdef GLOBAL_DEMUX_TIMEOUT_EN
    $display("[TB] timeout sequence, feature enabled");
    // Valid must be visible for exactly TIMEOUT cycles; target 1's ready is
    // held high to show it is ignored.
    for (int i = 0; i < TIMEOUT; i++)
      runVec(mk($sformatf("to_stall%0d", i), 0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 8'h9A, 0, 8'h00, 1, 0));
    runVec(mk("to_dropped", 0, 0, 0, 8'h00, 0, 1, 0, 1, 0, 8'h00, 0, 8'h00, 0, 1));
    runVec(mk("to_sticky1", 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 1));
    runVec(mk("to_sticky2", 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 1));
    runVec(mk("to_clr",     0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 8'h00, 0, 1));
    runVec(mk("to_cleared", 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0));
    // Second timeout with err_clr held high the whole time: set must win.
    runVec(mk("sw_accept",  0, 1, 1, 8'hC3, 0, 0, 1, 1, 0, 8'h00, 0, 8'h00, 0, 0));
    for (int i = 0; i < TIMEOUT; i++)
      runVec(mk($sformatf("sw_stall%0d", i), 0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 1, 8'hC3, 1, 0));
    runVec(mk("sw_setwins", 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 1));
    runVec(mk("sw_clr",     0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 8'h00, 0, 1));
    runVec(mk("sw_cleared", 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0));
`else
    $display("[TB] timeout sequence, feature disabled");
    // With no counter the transfer is held indefinitely and err_clr does
    // nothing; completion still works afterwards.
    for (int i = 0; i < TIMEOUT + 4; i++)
      runVec(mk($sformatf("nt_stall%0d", i), 0, 0, 0, 8'h00, 0, 1, 1, 0, 1, 8'h9A, 0, 8'h00, 1, 0));
    runVec(mk("nt_done", 0, 0, 0, 8'h00, 1, 0, 0, 1, 1, 8'h9A, 0, 8'h00, 1, 0));
    runVec(mk("nt_idle", 0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/global_demux_wr.md
Name: global_demux_wr

Overview:
- Write-side counterpart of the global read-select mux: steers one write word from the core to one of two peripheral targets (target 0 = GPIO, target 1 = FACT) using a valid/ready handshake on every port.
- Holds exactly one transfer in flight and supports back-to-back issue.
- Sits between the core's store path and the GPIO/FACT write ports.

Parameters:
- WIDTH, 8: data width in bits.
- TIMEOUT, 16: cycles a target may stall before the transfer is dropped. Used only with GLOBAL_DEMUX_TIMEOUT_EN; must be at least 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  core presents a write.
- in_ready  output  1  demux accepts the write this cycle.
- s  input  1  target select, sampled on acceptance: 0 = target 0, 1 = target 1.
- d  input  WIDTH  write data.
- out0_valid  output  1  write pending to target 0.
- out0_ready  input  1  target 0 accepts.
- y0  output  WIDTH  data to target 0.
- out1_valid  output  1  write pending to target 1.
- out1_ready  input  1  target 1 accepts.
- y1  output  WIDTH  data to target 1.
- busy  output  1  a transfer is held.
- err_clr  input  1  clears timeout_err.
- timeout_err  output  1  sticky; a transfer was dropped.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high: rst is sampled on the rising edge of clk.
  - Reset forces state IDLE and clears sel_r, data_r, the stall counter and timeout_err.
  - While in reset and in the cycle after: out0_valid = out1_valid = 0, y0 = y1 = 0, busy = 0.
- State machine, two states (IDLE, HOLD):
  - IDLE:
    - in_ready = 1 (0 while rst is high).
    - On in_valid: capture sel_r <= s and data_r <= d, go to HOLD.
  - HOLD:
    - busy = 1.
    - out<sel_r>_valid = 1. The other valid = 0.
    - y<sel_r> = data_r. The unselected y = 0.
  - Registered outputs: valid and data appear the cycle after acceptance. Latency is 1 cycle from acceptance to outN_valid.
- Completion: in HOLD, out<sel_r>_ready = 1 completes the transfer at that edge.
  - in_ready = 1 in that same cycle (combinational from state and the selected ready only).
  - If in_valid = 1 as well: capture the new s/d and stay in HOLD. Back-to-back transfers give one transfer per cycle.
  - Otherwise go to IDLE.
- Ready from the unselected target is ignored in all states.
- s and d are don't-care unless in_valid and in_ready are both high.
- data_r and sel_r must not change while HOLD is stalled.
- Stall counter (feature on only):
  - Counts consecutive HOLD cycles with the selected ready = 0.
  - Resets to 0 on completion, on new capture and in IDLE.
  - Width is clog2(TIMEOUT+1).
- Reset mid-HOLD: the transfer is discarded silently and timeout_err is not set.

Optional Feature:
- Macro: GLOBAL_DEMUX_TIMEOUT_EN.
- Defined:
  - When the counter reaches TIMEOUT, the held transfer is dropped at that edge: the state goes to IDLE and timeout_err <= 1.
  - The dropped transfer's valid is therefore seen for exactly TIMEOUT cycles.
  - timeout_err stays 1 until err_clr = 1.
  - If err_clr and a new timeout occur in the same cycle, set wins.
- Undefined:
  - No counter is built.
  - HOLD waits indefinitely.
  - timeout_err is tied to 0 and err_clr is ignored.

Test Plan:
- Reset: assert rst for 2 cycles while in_valid = 1 -> in_ready = 0, all valids and y = 0, busy = 0 during reset and on the first cycle after.
- Single write: s=0, d=8'hA5 for one cycle, out0_ready=1 -> next cycle out0_valid=1 and y0=8'hA5; out1_valid=0 and y1=0; then IDLE, busy=0.
- Back-to-back: s=1/d=8'h11 then s=0/d=8'h22 on consecutive cycles, both readies high -> out1_valid with 8'h11 in cycle 1, out0_valid with 8'h22 in cycle 2, in_ready high throughout.
- Backpressure: s=1, d=8'h3C, out1_ready=0 for 5 cycles then 1, out0_ready=1 throughout -> y1 stays 8'h3C, in_ready=0 for 5 cycles, out0_valid never asserted.
- Timeout (macro on, TIMEOUT=16): s=0, out0_ready=0 forever -> out0_valid high exactly 16 cycles then 0; timeout_err=1 and held until err_clr pulse; with macro off, valid holds and timeout_err=0.
- Reset mid-HOLD: stall target 1 for 3 cycles, pulse rst -> next cycle out1_valid=0, busy=0, timeout_err=0.
